// File: rtl/or16_arb.sv
// Two-requester round-robin arbiter feeding one shared 16-bit OR unit into a
// single-entry registered output slot, with saturating per-requester grant counters.

module or16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output logic [15:0] o_y
);
  assign o_y = i_a | i_b;
endmodule

module or16_arb #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             r0_valid,
  input  logic [15:0]      r0_a,
  input  logic [15:0]      r0_b,
  output logic             r0_ready,
  input  logic             r1_valid,
  input  logic [15:0]      r1_a,
  input  logic [15:0]      r1_b,
  output logic             r1_ready,
  output logic             out_valid,
  output logic [15:0]      out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt0,
  output logic [CNT_W-1:0] cnt1
);

  typedef enum logic {StEmpty, StFull} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_last;
  logic [15:0]      r_data;
  logic             r_id;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;
  logic [CNT_W-1:0] w_cnt0_nxt;
  logic [CNT_W-1:0] w_cnt1_nxt;

  logic             w_slot_free;
  logic             w_any_req;
  logic             w_grant;
  logic             w_win;
  logic [15:0]      w_op_a;
  logic [15:0]      w_op_b;
  logic [15:0]      w_or;

  // Only contention consults r_last; a lone requester always wins.
  assign w_any_req = r0_valid | r1_valid;
  assign w_win     = (r0_valid & r1_valid) ? ~r_last : ~r0_valid;

  assign w_op_a = w_win ? r1_a : r0_a;
  assign w_op_b = w_win ? r1_b : r0_b;

  or16 u_or16 (
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_y (w_or)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StEmpty: if (w_grant) w_state_nxt = StFull;
      StFull:  if (out_ready && !w_grant) w_state_nxt = StEmpty;
    endcase
  end

  // FSM: outputs; ready ports are forced low while reset is held
  always_comb begin
    w_slot_free = (r_state == StEmpty) | out_ready;
    w_grant     = w_slot_free & w_any_req;
    out_valid   = (r_state == StFull);
    r0_ready    = rst_n & w_grant & ~w_win;
    r1_ready    = rst_n & w_grant & w_win;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= 16'h0000;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_data <= w_or;
      r_id   <= w_win;
      r_last <= w_win;
    end
  end

  always_comb begin
    w_cnt0_nxt = r_cnt0;
    w_cnt1_nxt = r_cnt1;
    if (w_grant && !w_win && (r_cnt0 != {CNT_W{1'b1}})) w_cnt0_nxt = r_cnt0 + CNT_W'(1);
    if (w_grant && w_win && (r_cnt1 != {CNT_W{1'b1}}))  w_cnt1_nxt = r_cnt1 + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      r_cnt0 <= w_cnt0_nxt;
      r_cnt1 <= w_cnt1_nxt;
    end
  end

  assign out_data = r_data;
  assign out_id   = r_id;
  assign cnt0     = r_cnt0;
  assign cnt1     = r_cnt1;

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    !(r0_ready && r1_ready));

  a_stall_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data) && $stable(out_id)));

endmodule

// File: tb/tb_or16_arb.sv
// Directed bench for or16_arb: stimulus pushes hand-computed results into a
// scoreboard queue, an independent monitor pops on every output handshake.

module tb_or16_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r0_valid, r1_valid, out_ready;
  logic [15:0] r0_a, r0_b, r1_a, r1_b;
  logic        r0_ready, r1_ready, out_valid, out_id;
  logic [15:0] out_data;
  logic [7:0]  cnt0, cnt1;

  logic        s_r0_ready, s_r1_ready, s_out_valid, s_out_id;
  logic [15:0] s_out_data;
  logic [1:0]  s_cnt0, s_cnt1;

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;
  logic [16:0] sb[$];

  always #5 clk = ~clk;

  or16_arb #(.CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_ready(r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_ready(r1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_id(out_id), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1)
  );

  // Narrow-counter copy on the same stimulus, for saturation.
  or16_arb #(.CNT_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n),
    .r0_valid(r0_valid), .r0_a(r0_a), .r0_b(r0_b), .r0_ready(s_r0_ready),
    .r1_valid(r1_valid), .r1_a(r1_a), .r1_b(r1_b), .r1_ready(s_r1_ready),
    .out_valid(s_out_valid), .out_data(s_out_data), .out_id(s_out_id), .out_ready(out_ready),
    .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic cyc(input logic v0, input logic [15:0] a0, input logic [15:0] b0,
                     input logic v1, input logic [15:0] a1, input logic [15:0] b1,
                     input logic ordy, input logic e0, input logic e1);
    r0_valid = v0; r0_a = a0; r0_b = b0;
    r1_valid = v1; r1_a = a1; r1_b = b1;
    out_ready = ordy;
    @(negedge clk);
    chk("r0_ready", {31'b0, r0_ready}, {31'b0, e0});
    chk("r1_ready", {31'b0, r1_ready}, {31'b0, e1});
    if (e0) sb.push_back({1'b0, a0 | b0});
    if (e1) sb.push_back({1'b1, a1 | b1});
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [16:0] exp_r;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_result: got id=%0d data=%h, expected none", out_id, out_data);
      end else begin
        exp_r = sb.pop_front();
        chk("res_id", {31'b0, out_id}, {31'b0, exp_r[16]});
        chk("res_data", {16'b0, out_data}, {16'b0, exp_r[15:0]});
      end
    end
  end

  initial begin
    logic [15:0] ra0, rb0, ra1, rb1;
    logic        e0;

    rst_n = 1'b0;
    r0_valid = 1'b1; r0_a = 16'h00F0; r0_b = 16'h0F0F;
    r1_valid = 1'b0; r1_a = 16'h0;    r1_b = 16'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, out_data}, 32'h0);
    chk("rst_out_id", {31'b0, out_id}, 32'd0);
    chk("rst_cnt0", {24'b0, cnt0}, 32'd0);
    chk("rst_cnt1", {24'b0, cnt1}, 32'd0);
    chk("rst_r0_ready", {31'b0, r0_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // First grant right after release
    cyc(1, 16'h00F0, 16'h0F0F, 0, 16'h0, 16'h0, 1, 1, 0);
    chk("first_out_valid", {31'b0, out_valid}, 32'd1);
    chk("first_out_data", {16'b0, out_data}, 32'h0FFF);
    chk("first_out_id", {31'b0, out_id}, 32'd0);
    chk("first_cnt0", {24'b0, cnt0}, 32'd1);
    chk("first_cnt1", {24'b0, cnt1}, 32'd0);

    // Stall, then async reset while the result is held
    cyc(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0);
    r0_valid = 1'b1; r0_a = 16'h1200; r0_b = 16'h0034;
    r1_valid = 1'b1; r1_a = 16'hA000; r1_b = 16'h0BCD;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_cnt0", {24'b0, cnt0}, 32'd0);
    chk("arst_out_data", {16'b0, out_data}, 32'h0);
    sb.delete();
    @(negedge clk);
    chk("arst_r0_ready", {31'b0, r0_ready}, 32'd0);
    chk("arst_r1_ready", {31'b0, r1_ready}, 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin under contention: 0,1,0,1
    cyc(1, 16'h1200, 16'h0034, 1, 16'hA000, 16'h0BCD, 1, 1, 0);
    cyc(1, 16'h5000, 16'h0006, 1, 16'hA000, 16'h0BCD, 1, 0, 1);
    cyc(1, 16'h5000, 16'h0006, 1, 16'h00FF, 16'hFF00, 1, 1, 0);
    cyc(1, 16'h8001, 16'h0180, 1, 16'h00FF, 16'hFF00, 1, 0, 1);
    chk("rr_cnt0", {24'b0, cnt0}, 32'd2);
    chk("rr_cnt1", {24'b0, cnt1}, 32'd2);

    // Stall with both requesters pending
    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'h8001, 16'h0180, 1, 16'h0F00, 16'h00F0, 0, 0, 0);
      chk("stall_valid", {31'b0, out_valid}, 32'd1);
      chk("stall_data", {16'b0, out_data}, 32'hFFFF);
      chk("stall_id", {31'b0, out_id}, 32'd1);
    end
    cyc(1, 16'h8001, 16'h0180, 1, 16'h0F00, 16'h00F0, 1, 1, 0);
    chk("refill_valid", {31'b0, out_valid}, 32'd1);
    chk("refill_id", {31'b0, out_id}, 32'd0);
    chk("refill_cnt0", {24'b0, cnt0}, 32'd3);

    // Two more requester-0 grants: 5 total, narrow counter pinned at 3
    cyc(1, 16'h1111, 16'h2222, 1, 16'h0F00, 16'h00F0, 1, 0, 1);
    cyc(1, 16'h1111, 16'h2222, 0, 16'h0, 16'h0, 1, 1, 0);
    cyc(1, 16'h0001, 16'h0002, 0, 16'h0, 16'h0, 1, 1, 0);
    chk("cnt0_main", {24'b0, cnt0}, 32'd5);
    chk("cnt0_sat", {30'b0, s_cnt0}, 32'd3);
    chk("cnt1_sat", {30'b0, s_cnt1}, 32'd3);
    chk("cnt1_main", {24'b0, cnt1}, 32'd3);

    // Drain without refill: data and id hold
    cyc(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 0);
    chk("drain_valid", {31'b0, out_valid}, 32'd0);
    chk("drain_data", {16'b0, out_data}, 32'h0003);
    chk("drain_id", {31'b0, out_id}, 32'd0);

    // Random operands, continuous contention; last grant was 0, so 1 leads
    ra0 = 16'($urandom); rb0 = 16'($urandom);
    ra1 = 16'($urandom); rb1 = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      e0 = (i % 2 == 1);
      cyc(1, ra0, rb0, 1, ra1, rb1, 1, e0, !e0);
      if (e0) begin ra0 = 16'($urandom); rb0 = 16'($urandom); end
      else    begin ra1 = 16'($urandom); rb1 = 16'($urandom); end
    end
    cyc(0, 16'h0, 16'h0, 0, 16'h0, 16'h0, 1, 0, 0);
    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 32'd0);
    chk("final_valid", {31'b0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/or16_arb.md
OR16_ARB -- requirements
Module: or16_arb

Interface
REQ-001 Parameter CNT_W, default 8: width of the per-requester grant counters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset: asserted immediately on falling edge, deasserted synchronously to clk.
REQ-004 r0_valid  input  1  requester 0 has an operand pair.
REQ-005 r0_a, r0_b  input  16 each  requester 0 operands.
REQ-006 r0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 r1_valid, r1_a, r1_b, r1_ready  same as REQ-004..006, for requester 1.
REQ-008 out_valid  output  1  registered result held.
REQ-009 out_data  output  16  bitwise OR of the granted operand pair.
REQ-010 out_id  output  1  index of the requester that owns out_data.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 cnt0, cnt1  output  CNT_W each  number of grants issued to requester 0 / 1.

Function
REQ-013 Single shared or16 instance; its a/b inputs are muxed from the granted requester; no other OR logic on the data path.
REQ-014 Transfer on each port = valid & ready in the same cycle; the handshake is complete on that edge.
REQ-015 Slot free when out_valid=0, or when out_valid=1 and out_ready=1 (drain and refill in the same cycle).
REQ-016 Grant only when the slot is free and at least one rX_valid=1; at most one grant per cycle.
REQ-017 r0_ready / r1_ready combinational: 1 only for the granted requester in a grant cycle, else 0; never both 1.
REQ-018 Arbitration: if only one requester is valid, it wins; if both are valid, the requester not granted last wins (round-robin via 1-bit last register).
REQ-019 last updates only on a grant, to the granted index.
REQ-020 On a grant edge: out_data <= rX_a | rX_b of the winner; out_id <= winner; out_valid <= 1. Latency is exactly 1 cycle from grant to out_valid.
REQ-021 Drain without refill (out_valid & out_ready, no grant): out_valid <= 0. out_data and out_id hold their last values.
REQ-022 Stall (out_valid=1, out_ready=0): out_valid, out_data and out_id hold; both rX_ready=0.
REQ-023 out_data and out_id SHALL NOT change while out_valid=1 and out_ready=0.
REQ-024 Two-state view: EMPTY (out_valid=0), FULL (out_valid=1). EMPTY->FULL on grant; FULL->EMPTY on drain without grant; FULL->FULL on stall or on drain plus grant.
REQ-025 cntX increments by 1 on each grant to requester X; saturates at 2^CNT_W-1 (no wrap).
REQ-026 Sustained throughput with out_ready=1: one result per cycle; both requesters valid alternate 0,1,0,1.
REQ-027 Inputs seen while rX_ready=0 are ignored; the requester holds them until accepted.

Reset
REQ-028 While rst_n=0: out_valid=0, out_data=16'h0000, out_id=0, cnt0=cnt1=0, last=1 (requester 0 wins the first contention), r0_ready=r1_ready=0.
REQ-029 Reset mid-transaction discards any held result; no grant is issued in a cycle in which rst_n=0.
REQ-030 First grant can occur on the first rising edge after rst_n deasserts.

Verification
REQ-031 After reset, r0_valid=1, a=16'h00F0, b=16'h0F0F, out_ready=1 -> r0_ready=1 that cycle; next cycle out_valid=1, out_data=16'h0FFF, out_id=0, cnt0=1.
REQ-032 Both valid for 4 cycles, out_ready=1 -> grants 0,1,0,1; out_id sequence 0,1,0,1; cnt0=cnt1=2.
REQ-033 out_valid=1 with out_ready=0 for 3 cycles while both requesters are valid -> r0_ready=r1_ready=0, out_data stable; on out_ready=1, a new grant happens in the same cycle and out_valid stays 1.
REQ-034 CNT_W=2, 5 grants to requester 0 -> cnt0 saturates at 3.
REQ-035 rst_n pulsed low asynchronously while out_valid=1 -> out_valid=0 and counters=0 immediately; after release, first contention is won by requester 0.
REQ-036 Random operands on both ports vs. a scoreboard: every accepted pair yields exactly one result equal to a|b, tagged with the correct out_id, in per-requester order.
